// File: rtl/sys_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sys_ctrl_pkg : command codes, FSM states and register indices for sys_ctrl |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OPA      = 4'd5,
    OPB      = 4'd6,
    FUNC     = 4'd7,
    ALU_WAIT = 4'd8,
    SEND_LO  = 4'd9,
    SEND_HI  = 4'd10
  } state_e;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

endpackage : sys_ctrl_pkg
`default_nettype wire

// File: rtl/sys_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sys_ctrl : UART command sequencer driving the register file and the ALU    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int FUNC_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     rx_data_in,
  input  logic                 rx_valid_in,
  output logic [ADDR_W-1:0]    rf_addr_out,
  output logic                 rf_wr_en_out,
  output logic [WIDTH-1:0]     rf_wr_data_out,
  output logic                 rf_rd_en_out,
  input  logic [WIDTH-1:0]     rf_rd_data_in,
  input  logic                 rf_rd_valid_in,
  output logic                 alu_en_out,
  output logic [FUNC_W-1:0]    alu_func_out,
  input  logic [2*WIDTH-1:0]   alu_result_in,
  input  logic                 alu_valid_in,
  output logic                 tx_wr_en_out,
  output logic [WIDTH-1:0]     tx_wr_data_out,
  input  logic                 tx_full_in,
  output logic                 busy_out
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [2*WIDTH-1:0]  r_result;
  logic                r_send_hi;

  assign busy_out = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_result       <= '0;
      r_send_hi      <= 1'b0;
      rf_addr_out    <= '0;
      rf_wr_en_out   <= 1'b0;
      rf_wr_data_out <= '0;
      rf_rd_en_out   <= 1'b0;
      alu_en_out     <= 1'b0;
      alu_func_out   <= '0;
      tx_wr_en_out   <= 1'b0;
      tx_wr_data_out <= '0;
    end else begin
      // All strobes are single-cycle; the cases below re-assert them.
      rf_wr_en_out <= 1'b0;
      rf_rd_en_out <= 1'b0;
      alu_en_out   <= 1'b0;
      tx_wr_en_out <= 1'b0;

      case (r_state)
        IDLE: begin
          if (rx_valid_in) begin
            if (rx_data_in == WIDTH'(CMD_RF_WR))        r_state <= WR_ADDR;
            else if (rx_data_in == WIDTH'(CMD_RF_RD))   r_state <= RD_ADDR;
            else if (rx_data_in == WIDTH'(CMD_ALU_OP))  r_state <= OPA;
            else if (rx_data_in == WIDTH'(CMD_ALU_NOP)) r_state <= FUNC;
          end
        end

        WR_ADDR: begin
          if (rx_valid_in) begin
            r_addr  <= rx_data_in[ADDR_W-1:0];
            r_state <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (rx_valid_in) begin
            rf_wr_en_out   <= 1'b1;
            rf_addr_out    <= r_addr;
            rf_wr_data_out <= rx_data_in;
            r_state        <= IDLE;
          end
        end

        RD_ADDR: begin
          if (rx_valid_in) begin
            rf_rd_en_out <= 1'b1;
            rf_addr_out  <= rx_data_in[ADDR_W-1:0];
            r_state      <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (rf_rd_valid_in) begin
            r_result  <= {{WIDTH{1'b0}}, rf_rd_data_in};
            r_send_hi <= 1'b0;
            r_state   <= SEND_LO;
          end
        end

        OPA: begin
          if (rx_valid_in) begin
            rf_wr_en_out   <= 1'b1;
            rf_addr_out    <= ADDR_W'(OPA_ADDR);
            rf_wr_data_out <= rx_data_in;
            r_state        <= OPB;
          end
        end

        OPB: begin
          if (rx_valid_in) begin
            rf_wr_en_out   <= 1'b1;
            rf_addr_out    <= ADDR_W'(OPB_ADDR);
            rf_wr_data_out <= rx_data_in;
            r_state        <= FUNC;
          end
        end

        FUNC: begin
          if (rx_valid_in) begin
            alu_en_out   <= 1'b1;
            alu_func_out <= rx_data_in[FUNC_W-1:0];
            r_state      <= ALU_WAIT;
          end
        end

        ALU_WAIT: begin
          if (alu_valid_in) begin
            r_result  <= alu_result_in;
            r_send_hi <= 1'b1;
            r_state   <= SEND_LO;
          end
        end

        // Read responses are one byte; ALU responses go out LSB first.
        SEND_LO: begin
          if (!tx_full_in) begin
            tx_wr_en_out   <= 1'b1;
            tx_wr_data_out <= r_result[WIDTH-1:0];
            r_state        <= r_send_hi ? SEND_HI : IDLE;
          end
        end

        SEND_HI: begin
          if (!tx_full_in) begin
            tx_wr_en_out   <= 1'b1;
            tx_wr_data_out <= r_result[2*WIDTH-1:WIDTH];
            r_state        <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : sys_ctrl
`default_nettype wire
